// File: rtl/spi_link_scheduler.sv
// Round-robin arbiter sharing one SPI byte engine among N_REQ requesters.
// Grants one request, launches the engine, waits for done or timeout, then enforces an idle gap.
module spi_link_scheduler #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     err,
    output logic                 eng_start,
    output logic [7:0]           eng_data,
    input  logic                 eng_done,
    output logic [2:0]           grant_id,
    output logic                 active
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic               start_q, start_d;
    logic               active_q, active_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   gap_q, gap_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [7:0]         win_data;
    logic [ID_W:0]      cand;
    logic [ID_W-1:0]    ptr_adv;
    logic [N_REQ-1:0]   grant_oh;

    // Round-robin search: offsets 0..N_REQ-1 from ptr, wrapping mod N_REQ; first live request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!win_found && req[j] && (cand == (ID_W+1)'(j))) begin
                    win_found = 1'b1;
                    win_idx   = ID_W'(j);
                    win_data  = req_data[8*j +: 8];
                end
            end
        end
    end

    assign ptr_adv  = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
    assign grant_oh = N_REQ'(1) << grant_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        start_d  = 1'b0;
        active_d = active_q;
        ack_d    = '0;
        err_d    = '0;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d  = win_idx;
                    data_d   = win_data;
                    start_d  = 1'b1;
                    active_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                // Done takes priority over a timeout landing on the same edge.
                if (eng_done || (tmo_q == TMO_LAST)) begin
                    if (eng_done) begin
                        ack_d = grant_oh;
                    end else begin
                        err_d = grant_oh;
                    end
                    ptr_d    = ptr_adv;
                    gap_d    = GAP_LAST;
                    active_d = 1'b0;
                    state_d  = S_GAP;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            ack_q    <= '0;
            err_q    <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            start_q  <= start_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign eng_start = start_q;
    assign eng_data  = data_q;
    assign grant_id  = grant_q;
    assign active    = active_q;

endmodule

// File: tb/tb_spi_link_scheduler.sv
// Bench for spi_link_scheduler: scenario tasks with randomized traffic checked
// against a round-robin/latency reference model kept in the bench.
module tb_spi_link_scheduler;

    localparam int NR  = 3;
    localparam int GAP = 16;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   err;
    logic            eng_start;
    logic [7:0]      eng_data;
    logic            eng_done;
    logic [2:0]      grant_id;
    logic            active;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_ptr = 0;

    spi_link_scheduler #(
        .N_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .eng_start(eng_start), .eng_data(eng_data),
        .eng_done(eng_done), .grant_id(grant_id), .active(active)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Reference: first live request at offsets 0..NR-1 from the pointer.
    function automatic int rr_pick(input logic [NR-1:0] m, input int p);
        for (int i = 0; i < NR; i++) begin
            if (m[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; eng_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Engine/requester stand-in: waits for a launch, answers done n cycles after it (n<0: never).
    task automatic run_xfer(input int n, input bit corrupt,
                            output bit started, output int id, output logic [7:0] data,
                            output int start_cyc, output int resp_c,
                            output logic [NR-1:0] r_ack, output logic [NR-1:0] r_err,
                            output int pulses, output bit stable);
        started = 0; id = -1; data = '0; start_cyc = 0; resp_c = -1;
        r_ack = '0; r_err = '0; pulses = 0; stable = 1;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if ((ack | err) !== '0) pulses++;
            if (eng_start === 1'b1) begin
                started = 1;
                break;
            end
        end
        if (!started) return;
        id = int'(grant_id); data = eng_data; start_cyc = cyc;
        if (active !== 1'b1) stable = 0;
        for (int c = 1; c <= TMO + 4; c++) begin
            @(negedge clk);
            if (eng_start !== 1'b0) stable = 0;
            if (resp_c < 0 && eng_data !== data) stable = 0;
            if ((ack | err) !== '0) begin
                pulses++;
                if (resp_c < 0) begin
                    resp_c = c; r_ack = ack; r_err = err;
                    if (active !== 1'b0) stable = 0;
                    if (id >= 0 && id < NR) req[id] = 1'b0;
                end
            end else if (resp_c < 0 && active !== 1'b1) begin
                stable = 0;
            end
            if (corrupt && c == 1 && id >= 0 && id < NR) begin
                req_data[8*id +: 8] = ~data;
                req[id] = 1'b0;
            end
            eng_done = (c == n);
            if (resp_c >= 0 && c >= resp_c + 3) break;
        end
        eng_done = 1'b0;
    endtask

    task automatic test_reset();
        int starts, pulses;
        do_reset();
        n_vec++; if (ack !== '0)       begin n_err++; $display("FAIL reset_ack: got %b expected 000", ack); end
        n_vec++; if (err !== '0)       begin n_err++; $display("FAIL reset_err: got %b expected 000", err); end
        n_vec++; if (eng_start !== 0)  begin n_err++; $display("FAIL reset_start: got %b expected 0", eng_start); end
        n_vec++; if (eng_data !== 0)   begin n_err++; $display("FAIL reset_data: got %h expected 00", eng_data); end
        n_vec++; if (grant_id !== 0)   begin n_err++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_vec++; if (active !== 0)     begin n_err++; $display("FAIL reset_active: got %b expected 0", active); end
        starts = 0; pulses = 0;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (eng_start !== 1'b0 || active !== 1'b0) starts++;
            if ((ack | err) !== '0) pulses++;
        end
        n_vec++; if (starts !== 0) begin n_err++; $display("FAIL idle_no_start: got %0d expected 0", starts); end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL idle_done_ignored: got %0d expected 0", pulses); end
    endtask

    task automatic test_single();
        bit st, stb; int id, sc, rc, pl, starts; logic [7:0] d; logic [NR-1:0] ra, re;
        do_reset();
        req_data = {8'($urandom), 8'($urandom), 8'hD7};
        req = 3'b001;
        run_xfer(20, 0, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (st !== 1)      begin n_err++; $display("FAIL single_start: got %0d expected 1", st); end
        n_vec++; if (id !== 0)      begin n_err++; $display("FAIL single_grant: got %0d expected 0", id); end
        n_vec++; if (d !== 8'hD7)   begin n_err++; $display("FAIL single_data: got %h expected d7", d); end
        n_vec++; if (rc !== 21)     begin n_err++; $display("FAIL single_latency: got %0d expected 21", rc); end
        n_vec++; if (ra !== 3'b001) begin n_err++; $display("FAIL single_ack: got %b expected 001", ra); end
        n_vec++; if (re !== 3'b000) begin n_err++; $display("FAIL single_err: got %b expected 000", re); end
        n_vec++; if (pl !== 1)      begin n_err++; $display("FAIL single_pulses: got %0d expected 1", pl); end
        n_vec++; if (stb !== 1)     begin n_err++; $display("FAIL single_stable: got %0d expected 1", stb); end
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (eng_start !== 1'b0) starts++;
        end
        n_vec++; if (starts !== 0)  begin n_err++; $display("FAIL single_no_relaunch: got %0d expected 0", starts); end
    endtask

    task automatic test_back_to_back();
        bit st, stb; int id, sc, rc, pl, n, prev_ack; logic [7:0] d, exp_d; logic [NR-1:0] ra, re;
        do_reset();
        req_data = 24'($urandom);
        req = 3'b111;
        prev_ack = -1;
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 40));
            exp_d = req_data[8*(t % NR) +: 8];
            run_xfer(n, 0, st, id, d, sc, rc, ra, re, pl, stb);
            n_vec++; if (id !== t % NR)   begin n_err++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", t, id, t % NR); end
            n_vec++; if (d !== exp_d)     begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", t, d, exp_d); end
            n_vec++; if (rc !== n + 1)    begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", t, rc, n + 1); end
            n_vec++; if (ra !== NR'(1) << (t % NR) || re !== '0)
                begin n_err++; $display("FAIL b2b_ack[%0d]: got ack %b err %b expected ack %b", t, ra, re, NR'(1) << (t % NR)); end
            if (prev_ack >= 0) begin
                n_vec++; if (sc - prev_ack < GAP + 1)
                    begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d expected >=%0d", t, sc - prev_ack, GAP + 1); end
            end
            prev_ack = sc + rc;
            if (id >= 0 && id < NR) begin
                m_ptr = (id + 1) % NR;
                req_data[8*id +: 8] = 8'($urandom);
                req[id] = 1'b1;
            end
        end
    endtask

    task automatic test_timeout();
        bit st, stb; int id, sc, rc, pl, first_end; logic [7:0] d; logic [NR-1:0] ra, re;
        do_reset();
        req_data = 24'($urandom);
        req = 3'b011;
        run_xfer(-1, 0, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (id !== 0)        begin n_err++; $display("FAIL tmo_grant: got %0d expected 0", id); end
        n_vec++; if (rc !== TMO + 1)  begin n_err++; $display("FAIL tmo_latency: got %0d expected %0d", rc, TMO + 1); end
        n_vec++; if (re !== 3'b001 || ra !== 3'b000)
            begin n_err++; $display("FAIL tmo_err: got err %b ack %b expected err 001 ack 000", re, ra); end
        n_vec++; if (pl !== 1 || stb !== 1)
            begin n_err++; $display("FAIL tmo_pulse: got pulses %0d stable %0d expected 1 1", pl, stb); end
        first_end = sc + rc;
        m_ptr = 1;
        run_xfer(5, 0, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (id !== rr_pick(3'b010, m_ptr))
            begin n_err++; $display("FAIL tmo_next_grant: got %0d expected %0d", id, rr_pick(3'b010, m_ptr)); end
        n_vec++; if (ra !== 3'b010)   begin n_err++; $display("FAIL tmo_next_ack: got %b expected 010", ra); end
        n_vec++; if (sc - first_end < GAP + 1)
            begin n_err++; $display("FAIL tmo_gap: got %0d expected >=%0d", sc - first_end, GAP + 1); end
    endtask

    task automatic test_done_at_timeout();
        bit st, stb; int id, sc, rc, pl, exp_id; logic [7:0] d; logic [NR-1:0] ra, re, m;
        do_reset();
        req_data = 24'($urandom);
        m = NR'($urandom_range(1, 7));
        req = m;
        exp_id = rr_pick(m, m_ptr);
        run_xfer(TMO, 0, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (id !== exp_id)   begin n_err++; $display("FAIL edge_grant: got %0d expected %0d", id, exp_id); end
        n_vec++; if (rc !== TMO + 1)  begin n_err++; $display("FAIL edge_latency: got %0d expected %0d", rc, TMO + 1); end
        n_vec++; if (ra !== NR'(1) << exp_id || re !== '0)
            begin n_err++; $display("FAIL edge_ack_wins: got ack %b err %b expected ack %b err 000", ra, re, NR'(1) << exp_id); end
        n_vec++; if (pl !== 1)        begin n_err++; $display("FAIL edge_pulses: got %0d expected 1", pl); end
    endtask

    task automatic test_reset_mid();
        bit st, stb, seen; int id, sc, rc, pl; logic [7:0] d; logic [NR-1:0] ra, re;
        do_reset();
        req_data = 24'($urandom);
        req = 3'b010;
        run_xfer(3, 0, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (id !== 1) begin n_err++; $display("FAIL rst_pre_grant: got %0d expected 1", id); end
        req = 3'b100;
        seen = 0;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (eng_start === 1'b1) begin seen = 1; break; end
        end
        repeat (5) @(negedge clk);
        n_vec++; if (!seen || grant_id !== 3'd2 || active !== 1'b1)
            begin n_err++; $display("FAIL rst_mid_state: got start %0d grant %0d active %b expected 1 2 1", seen, grant_id, active); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({ack, err, eng_start, eng_data, grant_id, active} !== '0)
            begin n_err++; $display("FAIL rst_mid_outputs: got %b %b %b %h %0d %b expected all 0", ack, err, eng_start, eng_data, grant_id, active); end
        rst = 1'b0;
        m_ptr = 0;
        req = 3'b111;
        run_xfer(7, 0, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (id !== rr_pick(3'b111, m_ptr))
            begin n_err++; $display("FAIL rst_ptr_cleared: got %0d expected %0d", id, rr_pick(3'b111, m_ptr)); end
        n_vec++; if (pl !== 1 || ra !== 3'b001)
            begin n_err++; $display("FAIL rst_no_stale: got pulses %0d ack %b expected 1 001", pl, ra); end
    endtask

    task automatic test_data_change();
        bit st, stb; int id, sc, rc, pl; logic [7:0] d, orig; logic [NR-1:0] ra, re;
        do_reset();
        req_data = 24'($urandom);
        orig = req_data[15:8];
        req = 3'b010;
        run_xfer(10, 1, st, id, d, sc, rc, ra, re, pl, stb);
        n_vec++; if (d !== orig)     begin n_err++; $display("FAIL chg_data: got %h expected %h", d, orig); end
        n_vec++; if (stb !== 1)      begin n_err++; $display("FAIL chg_stable: got %0d expected 1", stb); end
        n_vec++; if (ra !== 3'b010 || pl !== 1)
            begin n_err++; $display("FAIL chg_ack: got %b pulses %0d expected 010 1", ra, pl); end
    endtask

    task automatic test_random();
        bit st, stb; int id, sc, rc, pl, n, exp_id, exp_rc; logic [7:0] d, exp_d; logic [NR-1:0] ra, re, m;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            m = NR'($urandom_range(1, 7));
            req_data = 24'($urandom);
            req = m;
            exp_id = rr_pick(m, m_ptr);
            exp_d = req_data[8*exp_id +: 8];
            n = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TMO));
            exp_rc = (n > 0) ? n + 1 : TMO + 1;
            run_xfer(n, 0, st, id, d, sc, rc, ra, re, pl, stb);
            n_vec++; if (id !== exp_id || d !== exp_d)
                begin n_err++; $display("FAIL rnd_grant[%0d]: got id %0d data %h expected id %0d data %h", t, id, d, exp_id, exp_d); end
            n_vec++; if (rc !== exp_rc)
                begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, rc, exp_rc); end
            n_vec++; if ((n > 0 && (ra !== NR'(1) << exp_id || re !== '0)) || (n < 0 && (re !== NR'(1) << exp_id || ra !== '0)))
                begin n_err++; $display("FAIL rnd_resp[%0d]: got ack %b err %b expected bit %0d (timeout %0d)", t, ra, re, exp_id, n < 0); end
            n_vec++; if (pl !== 1 || stb !== 1)
                begin n_err++; $display("FAIL rnd_pulse[%0d]: got pulses %0d stable %0d expected 1 1", t, pl, stb); end
            m_ptr = (exp_id + 1) % NR;
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; eng_done = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        test_data_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
